// File: rtl/core_inst_buffer.sv
// Instruction queue between fetch F2 and decode. It accepts up to two
// instructions per cycle and presents up to two in program order.
module core_inst_buffer #(
  parameter int DEPTH               = 8,
  parameter int ATTACHED_INFO_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush_i,
  input  logic [1:0]                       valid_i,
  input  logic [31:0]                      pc_i,
  input  logic [63:0]                      inst_i,
  input  logic [ATTACHED_INFO_WIDTH-1:0]   attached_i,
  output logic                             ready_o,
  output logic [1:0]                       valid_o,
  output logic [63:0]                      pc_o,
  output logic [63:0]                      inst_o,
  output logic [2*ATTACHED_INFO_WIDTH-1:0] attached_o,
  input  logic [1:0]                       issue_i
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] ROOM_FOR_TWO = (PW+1)'(DEPTH - 2);
  localparam logic [PW:0] FULL_COUNT   = (PW+1)'(DEPTH);
  localparam logic [PW:0] TWO          = (PW+1)'(2);

  logic [31:0]                    inst_mem [DEPTH];
  logic [31:0]                    pc_mem   [DEPTH];
  logic [ATTACHED_INFO_WIDTH-1:0] att_mem  [DEPTH];

  logic [PW-1:0] head, tail, head1, tail1;
  logic [PW:0]   count;

  logic          push, pop0, pop1;
  logic [1:0]    push_n, pop_n;
  logic          first_sel;
  logic [31:0]   first_inst, first_pc, second_pc;
  logic          unused_pc_lsbs;

  assign unused_pc_lsbs = ^pc_i[2:0];

  always_comb begin
    ready_o    = count <= ROOM_FOR_TWO;
    valid_o[0] = count != '0;
    valid_o[1] = count >= TWO;

    push   = ready_o && (|valid_i) && !flush_i;
    push_n = {1'b0, valid_i[0]} + {1'b0, valid_i[1]};

    // issue_i=10 pops nothing: slot1 only pops together with slot0
    pop0  = issue_i[0] && valid_o[0];
    pop1  = issue_i[1] && issue_i[0] && valid_o[1];
    pop_n = {1'b0, pop0} + {1'b0, pop1};

    // A lone slot-1 instruction is compacted down to the tail entry
    first_sel  = !valid_i[0];
    first_inst = first_sel ? inst_i[63:32] : inst_i[31:0];
    first_pc   = {pc_i[31:3], first_sel, 2'b00};
    second_pc  = {pc_i[31:3], 1'b1, 2'b00};

    head1 = head + PW'(1);
    tail1 = tail + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_n);
      tail  <= tail + (push ? PW'(push_n) : '0);
      count <= count + (push ? (PW+1)'(push_n) : '0) - (PW+1)'(pop_n);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      inst_mem[tail] <= first_inst;
      pc_mem[tail]   <= first_pc;
      att_mem[tail]  <= attached_i;
      if (&valid_i) begin
        inst_mem[tail1] <= inst_i[63:32];
        pc_mem[tail1]   <= second_pc;
        att_mem[tail1]  <= attached_i;
      end
    end
  end

  always_comb begin
    inst_o     = {inst_mem[head1], inst_mem[head]};
    pc_o       = {pc_mem[head1], pc_mem[head]};
    attached_o = {att_mem[head1], att_mem[head]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count <= FULL_COUNT);
      assert (valid_o != 2'b10);
      assert (tail == head + count[PW-1:0]);
    end
  end

endmodule

// File: doc/core_inst_buffer.md
Name: core_inst_buffer

Overview:
- Decoupling instruction queue between the fetch stage's F2 output and decode.
- Accepts up to two instructions per cycle from the fetch F2 output (valid/pc/inst/attached), compacts them in program order, and presents up to two in-order instructions per cycle to decode.
- Its ready_o drives the fetch stage's ready_i, so fetch stalls (skids) only when the buffer cannot absorb a full fetch packet.

Parameters:
- DEPTH, 8, number of single-instruction entries; power of two, >= 4.
- ATTACHED_INFO_WIDTH, 32, width of per-packet predictor info carried with each instruction.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush_i  input  1  pipeline flush; empties buffer.
- valid_i  input  2  per-slot valid of the fetch packet; slot k is at {pc_i[31:3], k, 2'b00}.
- pc_i  input  32  packet pc from fetch (pc_o of fetch).
- inst_i  input  2x32  slot instructions.
- attached_i  input  ATTACHED_INFO_WIDTH  predictor info; copied into every instruction pushed from this packet.
- ready_o  output  1  buffer can accept a full packet this cycle.
- valid_o  output  2  decode slot valid; always a prefix (01 or 11 or 00).
- pc_o  output  2x32  per-slot instruction pc.
- inst_o  output  2x32  per-slot instruction.
- attached_o  output  2xATTACHED_INFO_WIDTH  per-slot attached info.
- issue_i  input  2  decode consumes slot k this cycle.

Behaviour:
- Storage: DEPTH-entry circular array of {inst, pc, attached}.
- Pointers: head/tail of log2(DEPTH) bits wrapping modulo DEPTH, plus a count register of log2(DEPTH)+1 bits.
- Reset (rst=1 at clock edge): head=tail=count=0.
  - After reset: valid_o=00, ready_o=1; pc_o/inst_o/attached_o don't-care while invalid.
- ready_o = (DEPTH - count) >= 2. It depends only on registered count, never on issue_i or valid_i in the same cycle.
- Push accepted iff ready_o && |valid_i && !flush_i.
  - push_n = popcount(valid_i).
  - Pattern 11: slot0 written at tail, slot1 at tail+1.
  - Pattern 01 (slot0 only) or 10 (slot1 only): the single instruction is written at tail.
  - Its pc is {pc_i[31:3], slot, 2'b00}.
  - tail += push_n (mod DEPTH).
- Push with ready_o=0: ignored, no state change. Fetch holds data via its skid while ready_i=0.
- Outputs are a combinational read of head and head+1 (mod DEPTH):
  - valid_o[0] = count>=1.
  - valid_o[1] = count>=2.
- Pop:
  - pop0 = issue_i[0] && valid_o[0].
  - pop1 = issue_i[1] && issue_i[0] && valid_o[1].
  - issue_i=10 is illegal and is treated as 00.
  - pop_n = pop0 + pop1; head += pop_n.
- count_next = count + push_n - pop_n. Simultaneous push and pop in the same cycle are both applied.
  - Full (count=DEPTH) with pop 2 and push attempted: push rejected (ready_o was 0); count becomes DEPTH-2.
  - count=DEPTH-2 with push 2 and pop 2: count stays DEPTH-2.
- Latency: an instruction pushed in cycle N is visible on valid_o in cycle N+1 at the earliest. No bypass.
- Flush: flush_i=1 sets head=tail=count=0 next cycle. It overrides push and pop in that cycle. rst has priority over flush_i.
- Wrap-around: entries at indices DEPTH-1 and 0 present as slot0/slot1 correctly when head=DEPTH-1.
- Ordering: strict FIFO program order. No reordering and no dropping of accepted instructions.
- Assertions for verification:
  - count <= DEPTH at all times.
  - valid_o is never 10.
  - tail == (head+count) mod DEPTH.

Test Plan:
- Reset then idle → valid_o=00, ready_o=1, count=0.
- Push pc_i=0x1c000000, valid_i=11, inst 0xA/0xB, issue_i=00 → next cycle valid_o=11, pc_o={0x1c000000,0x1c000004}, inst_o={0xA,0xB}.
- Push valid_i=10 with pc_i=0x1c000010, empty buffer → next cycle valid_o=01, pc_o[0]=0x1c000014. A following issue_i=11 pops only 1 and count returns to 0.
- Fill with four 11-packets (DEPTH=8) and no issue → ready_o=0 at count=8. A 5th packet is ignored. Then issue_i=11 for one cycle → count=6, ready_o=1; order preserved.
- Steady state at count=2: push 11 and issue 11 every cycle for 20 cycles → count stays 2, pcs sequential, head/tail wrap past index 7 correctly.
- count=5 with push 11 and issue 11 in the same cycle as flush_i=1 → next cycle count=0, valid_o=00, ready_o=1. rst mid-stream also yields count=0.
